// File: rtl/sa_ram_rwsp_param_if.sv
// Port bundle for the parameterised one-write/one-read RAM.
// The testbench (or parent) drives through "master"; the RAM sits on "slave".
interface sa_ram_rwsp_param_if #(
  parameter int DW = 16,
  parameter int AW = 7,
  parameter int NL = 2
);
  logic [AW-1:0] ra;
  logic          re;
  logic          ore;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic [AW-1:0] wa;
  logic          we;
  logic [NL-1:0] wmask;
  logic [DW-1:0] di;
  logic          err_oor;
  logic [7:0]    coll_cnt;
  logic [31:0]   pwrbus_ram_pd;

  modport master (
    output ra, re, ore, wa, we, wmask, di, pwrbus_ram_pd,
    input  dout, dout_vld, err_oor, coll_cnt
  );

  modport slave (
    input  ra, re, ore, wa, we, wmask, di, pwrbus_ram_pd,
    output dout, dout_vld, err_oor, coll_cnt
  );
endinterface

// File: rtl/sa_ram_rwsp_param.sv
// Parametrised two-port FPGA RAM model: one masked write port, one read port
// with a registered address stage and a registered output stage.
// Tracks read validity, sticky out-of-range errors and a saturating count of
// same-cycle read/write address collisions.
module sa_ram_rwsp_param #(
  parameter int DW        = 16,
  parameter int DEPTH     = 80,
  parameter int AW        = 7,
  parameter int MASK_GRAN = 8,
  parameter int RDW_MODE  = 0
) (
  input  logic               clk,
  input  logic               rst,
  sa_ram_rwsp_param_if.slave bus
);

  localparam int NL = DW / MASK_GRAN;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  // Illegal geometries must never elaborate silently.
  if ((DW % MASK_GRAN) != 0) begin : g_bad_gran
    $fatal(1, "sa_ram_rwsp_param: DW must be a multiple of MASK_GRAN");
  end
  if ((2 ** AW) < DEPTH) begin : g_bad_aw
    $fatal(1, "sa_ram_rwsp_param: 2**AW must be >= DEPTH");
  end

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] ra_d;
  logic          rd_pend;
  logic [DW-1:0] dout_q;
  logic          dout_vld_q;
  logic          err_oor_q;
  logic [7:0]    coll_cnt_q;

  logic          wr_in_range;
  logic          rd_in_range;
  logic          wr_fire;
  logic          rd_coll;
  logic [DW-1:0] rdata;
  logic          unused_pwr;

  assign wr_in_range = ({1'b0, bus.wa} < DEPTH_W);
  assign rd_in_range = ({1'b0, ra_d} < DEPTH_W);
  assign wr_fire     = !rst && bus.we && wr_in_range;
  assign rd_coll     = !rst && bus.we && (bus.wa == ra_d);

  // The power bus has no functional effect in this model.
  assign unused_pwr = ^bus.pwrbus_ram_pd;

  // Masked write: only enabled lanes of an in-range word are updated.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < NL; i++) begin
        if (bus.wmask[i]) begin
          mem[bus.wa][i*MASK_GRAN +: MASK_GRAN] <= bus.di[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  // Read data seen by the output stage, including the same-edge write policy.
  always_comb begin
    rdata = '0;
    if (rd_in_range) begin
      rdata = mem[ra_d];
      if ((RDW_MODE == 1) && rd_coll) begin
        for (int i = 0; i < NL; i++) begin
          if (bus.wmask[i]) begin
            rdata[i*MASK_GRAN +: MASK_GRAN] = bus.di[i*MASK_GRAN +: MASK_GRAN];
          end
        end
      end
    end
  end

  // Address capture stage; a new capture wins over consumption by ore.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_d    <= '0;
      rd_pend <= 1'b0;
    end else if (bus.re) begin
      ra_d    <= bus.ra;
      rd_pend <= 1'b1;
    end else if (bus.ore) begin
      rd_pend <= 1'b0;
    end
  end

  // Output register stage; validity follows whether a capture was pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else if (bus.ore) begin
      dout_q     <= rdata;
      dout_vld_q <= rd_pend;
    end
  end

  // Sticky out-of-range flag for both write and consumed-read addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_oor_q <= 1'b0;
    end else if ((bus.we && !wr_in_range) || (bus.ore && rd_pend && !rd_in_range)) begin
      err_oor_q <= 1'b1;
    end
  end

  // Saturating count of cycles where both ports target the same address.
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_cnt_q <= '0;
    end else if (bus.we && bus.re && (bus.wa == bus.ra) && (coll_cnt_q != 8'hFF)) begin
      coll_cnt_q <= coll_cnt_q + 8'd1;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.err_oor  = err_oor_q;
  assign bus.coll_cnt = coll_cnt_q;

endmodule
